// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Instruction-address sequencer that feeds `main`. It issues a word-aligned
//   pc stream with a valid/stall handshake and takes branch/jump redirects.
//   A redirect that arrives while the consumer stalls is held until the next
//   accept edge. A run stops when the END_PC address is accepted, or when
//   MAX_STEPS pcs have been accepted; done/timeout report which one ended it.
//
// Ports:
//   clk_i          system clock; all state changes on the rising edge
//   rst_n_i        synchronous active-low reset
//   start_i        one-cycle pulse that begins or restarts a run
//   stall_i        consumer not ready; the current pc is not accepted
//   redirect_i     branch/jump taken
//   redirect_pc_i  redirect target address
//   pc_o           current instruction address (registered)
//   pc_valid_o     pc_o is meaningful (registered, high in RUN)
//   step_cnt_o     number of pcs accepted in this run
//   busy_o         high while in RUN
//   done_o         sticky run-complete flag
//   timeout_o      sticky, the run ended because MAX_STEPS was reached
//   align_err_o    sticky, a misaligned redirect target ended the run
//
// Build option:
//   PC_ALIGN_CHECK_EN  When defined, a redirect target with nonzero bits [1:0]
//                      ends the run and sets align_err_o; pc_o is not updated.
//                      When undefined, target bits [1:0] are cleared silently
//                      and align_err_o is tied low.
//
// States:
//   state | meaning
//   IDLE  | after reset; waiting for start_i
//   RUN   | issuing pcs; pc_valid_o and busy_o high
//   DONE  | run finished; pc_o and step_cnt_o hold; waiting for start_i
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] END_PC    = 32'h0000_0100,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STEPS = 250
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [31:0]      pc_o,
  output logic             pc_valid_o,
  output logic [CNT_W-1:0] step_cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             align_err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] MAX_STEPS_C = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

  logic [1:0]       state_q,      state_d;
  logic [31:0]      pc_q,         pc_d;
  logic             pc_valid_q,   pc_valid_d;
  logic             busy_q,       busy_d;
  logic [CNT_W-1:0] step_q,       step_d;
  logic             done_q,       done_d;
  logic             timeout_q,    timeout_d;
  logic             align_err_q,  align_err_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      pend_pc_q,    pend_pc_d;

  logic [CNT_W-1:0] step_inc;
  logic [31:0]      pc_seq;
  logic             tgt_take;
  logic [31:0]      tgt_raw;
  logic [31:0]      tgt_pc;
  logic             tgt_misaligned;

  assign step_inc = step_q + ONE_C;
  // Sequential successor; wraps modulo 2^32 with no flag.
  assign pc_seq   = pc_q + 32'd4;

  // A held redirect outranks one arriving on the accept edge itself.
  assign tgt_take = pend_valid_q | redirect_i;
  assign tgt_raw  = pend_valid_q ? pend_pc_q : redirect_pc_i;

`ifdef PC_ALIGN_CHECK_EN
  assign tgt_pc         = tgt_raw;
  assign tgt_misaligned = |tgt_raw[1:0];
`else
  assign tgt_pc         = tgt_raw & 32'hFFFF_FFFC;
  assign tgt_misaligned = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    busy_d       = busy_q;
    step_d       = step_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    align_err_d  = align_err_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d      = ST_RUN;
          pc_d         = RESET_PC;
          pc_valid_d   = 1'b1;
          busy_d       = 1'b1;
          step_d       = '0;
          done_d       = 1'b0;
          timeout_d    = 1'b0;
          align_err_d  = 1'b0;
          pend_valid_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (!stall_i) begin
          step_d       = step_inc;
          pend_valid_d = 1'b0;
          // Termination looks at the pc being accepted, so a finished run
          // leaves pc_o on the last accepted address rather than its successor.
          if (pc_q == END_PC) begin
            state_d    = ST_DONE;
            pc_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else if (step_inc == MAX_STEPS_C) begin
            state_d    = ST_DONE;
            pc_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            timeout_d  = 1'b1;
          end else if (tgt_take && tgt_misaligned) begin
            state_d     = ST_DONE;
            pc_valid_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            align_err_d = 1'b1;
          end else if (tgt_take) begin
            pc_d = tgt_pc;
          end else begin
            pc_d = pc_seq;
          end
        end else if (redirect_i) begin
          // Latest redirect seen during a stall wins.
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc_i;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        pc_valid_d   = 1'b0;
        busy_d       = 1'b0;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      pc_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      step_q       <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      align_err_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      busy_q       <= busy_d;
      step_q       <= step_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      align_err_q  <= align_err_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = pc_valid_q;
  assign step_cnt_o = step_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign timeout_o  = timeout_q;

`ifdef PC_ALIGN_CHECK_EN
  assign align_err_o = align_err_q;
`else
  // Never set in this build; kept as a register only so both builds share
  // the same state structure.
  assign align_err_o = align_err_q & 1'b0;
`endif

endmodule
